pi_ebus_seq: RTL and testbench
==============================

PI_EBUS_SEQ -- requirements
Module: pi_ebus_seq

Interface
Parameters (name, default, meaning):
REQ-001 DATA_W, 36, width of the EBUS data word captured during a PI function cycle.
REQ-002 TMO_CYC, 1024, number of clk_pi_h cycles allowed from demand assertion to ebus_xfer_h before timeout; legal range 4..65535.
REQ-003 FCN_CODE, 3'b001, EBUS function code driven on ebus_f_h during a PI function cycle.

Ports (name, direction, width, meaning):
REQ-004 clk_pi_h, in, 1, sole clock; all state changes on the rising edge.
REQ-005 mr_reset_l, in, 1, synchronous active-low reset.
REQ-006 ebus_pi_h, in, 7, PI request lines for levels 1..7; bit 0 is level 1, the highest priority.
REQ-007 pi_on_h, in, 1, PI system enable.
REQ-008 pi_level_on_h, in, 7, per-level enable mask.
REQ-009 pi_hold_h, in, 7, levels currently held (in service); a held level and all lower-priority levels are blocked.
REQ-010 ebus_grant_h, in, 1, EBUS ownership grant from the EBUS arbiter.
REQ-011 ebus_xfer_h, in, 1, device transfer acknowledge.
REQ-012 ebus_d_h, in, DATA_W, EBUS data.
REQ-013 ebus_req_h, out, 1, EBUS ownership request.
REQ-014 ebus_demand_h, out, 1, EBUS demand strobe.
REQ-015 ebus_f_h, out, 3, function code.
REQ-016 ebus_cs_h, out, 3, PI level being serviced, encoded 1..7; 0 when idle.
REQ-017 pi_vec_valid_h, out, 1, one-cycle pulse when pi_vec_h is valid.
REQ-018 pi_vec_h, out, DATA_W, captured interrupt function word.
REQ-019 pi_vec_level_h, out, 3, level of the captured word.
REQ-020 pi_timeout_h, out, 1, one-cycle pulse when a cycle aborts on timeout.
REQ-021 pi_busy_h, out, 1, high in every state except IDLE.

Function
REQ-022 Eligible set = ebus_pi_h & pi_level_on_h & {7{pi_on_h}}, with each level n removed if any pi_hold_h bit at level <= n is set.
REQ-023 State machine states: IDLE, REQ, DEMAND, XWAIT, RELEASE.
REQ-024 In IDLE, a non-empty eligible set latches the highest-priority level into the internal level register, asserts ebus_req_h and enters REQ the next cycle.
REQ-025 In REQ, the block waits for ebus_grant_h; the latched level does not change, even if a higher-priority request arrives.
REQ-026 When ebus_grant_h=1 in REQ, the next cycle: ebus_f_h=FCN_CODE, ebus_cs_h=latched level, ebus_demand_h=1, timeout counter cleared, state DEMAND.
REQ-027 In DEMAND, the timeout counter increments each cycle while ebus_xfer_h=0.
REQ-028 ebus_xfer_h=1 in DEMAND captures ebus_d_h into pi_vec_h and the level into pi_vec_level_h, drops ebus_demand_h next cycle, and enters XWAIT.
REQ-029 XWAIT waits for ebus_xfer_h=0, then enters RELEASE.
REQ-030 pi_vec_valid_h pulses for exactly one cycle on entry to RELEASE.
REQ-031 In RELEASE, ebus_req_h, ebus_f_h and ebus_cs_h drop to 0 and the state returns to IDLE the next cycle; a new cycle can start at the earliest one cycle later.
REQ-032 Timeout: if the counter reaches TMO_CYC-1 in DEMAND with ebus_xfer_h=0, then pi_timeout_h pulses once, ebus_demand_h drops, pi_vec_h is unchanged, and the state goes to RELEASE without pi_vec_valid_h.
REQ-033 If ebus_xfer_h and timeout occur in the same cycle, xfer wins and no timeout is reported.
REQ-034 If ebus_grant_h drops while in DEMAND or XWAIT, the block continues; grant is sampled only in REQ.
REQ-035 If pi_on_h=0 in REQ, the block abandons the request, drops ebus_req_h and returns to IDLE; in DEMAND and later the cycle completes.
REQ-036 ebus_demand_h is never high unless ebus_req_h is high.
REQ-037 ebus_f_h and ebus_cs_h are stable throughout the demand.

Reset
REQ-038 mr_reset_l=0 at a clock edge forces IDLE and sets every output, pi_vec_h, the level register and the counter to 0, from any state.
REQ-039 Reset asserted mid-cycle drops ebus_demand_h and ebus_req_h on the next edge, with no valid or timeout pulse.

Verification
REQ-040 Requests 7'b0010100 all enabled, pi_on_h=1, no hold, grant after 2 cycles, xfer after 3 cycles carrying data 36'o123456701234 -> ebus_cs_h=3, ebus_f_h=1, pi_vec_level_h=3, pi_vec_h=36'o123456701234, a single valid pulse.
REQ-041 Level 2 requesting with pi_hold_h bit 0 (level 1) set -> no ebus_req_h; clearing the hold -> cycle starts the next cycle.
REQ-042 TMO_CYC=8, no xfer -> pi_timeout_h pulses 8 cycles after demand rises, no valid pulse, state returns to IDLE.
REQ-043 Level 5 latched in REQ, then level 1 asserted before grant -> cycle serves level 5; level 1 is served next.
REQ-044 mr_reset_l=0 during DEMAND -> all outputs 0 on the next edge; after release, a pending request restarts the sequence normally.
REQ-045 Xfer arrives in the same cycle the counter reaches TMO_CYC-1 -> valid pulse only, pi_timeout_h stays 0.

Source files
------------

// File: rtl/pi_ebus_seq.sv
// Priority-interrupt EBUS sequencer: picks the highest eligible PI level, wins the
// EBUS, runs one function cycle to fetch the interrupt word, with a demand timeout.
module pi_ebus_seq #(
    parameter int          DATA_W   = 36,
    parameter int          TMO_CYC  = 1024,
    parameter logic [2:0]  FCN_CODE = 3'b001
) (
    input  logic              clk_pi_h,
    input  logic              mr_reset_l,
    input  logic [6:0]        ebus_pi_h,
    input  logic              pi_on_h,
    input  logic [6:0]        pi_level_on_h,
    input  logic [6:0]        pi_hold_h,
    input  logic              ebus_grant_h,
    input  logic              ebus_xfer_h,
    input  logic [DATA_W-1:0] ebus_d_h,
    output logic              ebus_req_h,
    output logic              ebus_demand_h,
    output logic [2:0]        ebus_f_h,
    output logic [2:0]        ebus_cs_h,
    output logic              pi_vec_valid_h,
    output logic [DATA_W-1:0] pi_vec_h,
    output logic [2:0]        pi_vec_level_h,
    output logic              pi_timeout_h,
    output logic              pi_busy_h
);

    typedef enum logic [2:0] {IDLE, REQ, DEMAND, XWAIT, RELEASE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    state_t            state_reg, state_next;
    logic [2:0]        level_reg, level_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              demand_reg, demand_next;
    logic [2:0]        f_reg, f_next;
    logic [2:0]        cs_reg, cs_next;
    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] vec_reg, vec_next;
    logic [2:0]        vec_level_reg, vec_level_next;
    logic              tmo_reg, tmo_next;

    logic [6:0] elig;
    logic [2:0] sel_level;

    // A held level blocks itself and every lower-priority (higher-index) level.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_elig
            assign elig[gi] = ebus_pi_h[gi] & pi_level_on_h[gi] & pi_on_h & ~(|pi_hold_h[gi:0]);
        end
    endgenerate

    always_comb begin
        sel_level = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (elig[i]) sel_level = 3'(i + 1);
        end
    end

    always_comb begin
        state_next     = state_reg;
        level_next     = level_reg;
        cnt_next       = cnt_reg;
        req_next       = req_reg;
        demand_next    = demand_reg;
        f_next         = f_reg;
        cs_next        = cs_reg;
        valid_next     = 1'b0;
        vec_next       = vec_reg;
        vec_level_next = vec_level_reg;
        tmo_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_level != 3'd0) begin
                    level_next = sel_level;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!pi_on_h) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else if (ebus_grant_h) begin
                    f_next      = FCN_CODE;
                    cs_next     = level_reg;
                    demand_next = 1'b1;
                    cnt_next    = 16'd0;
                    state_next  = DEMAND;
                end
            end
            DEMAND: begin
                // Transfer takes precedence over a simultaneous timeout.
                if (ebus_xfer_h) begin
                    vec_next       = ebus_d_h;
                    vec_level_next = level_reg;
                    demand_next    = 1'b0;
                    state_next     = XWAIT;
                end else if (cnt_reg == TMO_LAST) begin
                    tmo_next    = 1'b1;
                    demand_next = 1'b0;
                    req_next    = 1'b0;
                    f_next      = 3'd0;
                    cs_next     = 3'd0;
                    state_next  = RELEASE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            XWAIT: begin
                if (!ebus_xfer_h) begin
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    f_next     = 3'd0;
                    cs_next    = 3'd0;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pi_h) begin
        if (!mr_reset_l) begin
            state_reg     <= IDLE;
            level_reg     <= 3'd0;
            cnt_reg       <= 16'd0;
            req_reg       <= 1'b0;
            demand_reg    <= 1'b0;
            f_reg         <= 3'd0;
            cs_reg        <= 3'd0;
            valid_reg     <= 1'b0;
            vec_reg       <= '0;
            vec_level_reg <= 3'd0;
            tmo_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            cnt_reg       <= cnt_next;
            req_reg       <= req_next;
            demand_reg    <= demand_next;
            f_reg         <= f_next;
            cs_reg        <= cs_next;
            valid_reg     <= valid_next;
            vec_reg       <= vec_next;
            vec_level_reg <= vec_level_next;
            tmo_reg       <= tmo_next;
        end
    end

    assign ebus_req_h     = req_reg;
    assign ebus_demand_h  = demand_reg;
    assign ebus_f_h       = f_reg;
    assign ebus_cs_h      = cs_reg;
    assign pi_vec_valid_h = valid_reg;
    assign pi_vec_h       = vec_reg;
    assign pi_vec_level_h = vec_level_reg;
    assign pi_timeout_h   = tmo_reg;
    assign pi_busy_h      = (state_reg != IDLE);

endmodule

// File: tb/tb_pi_ebus_seq.sv
// Directed bench for pi_ebus_seq with a short timeout (TMO_CYC=8); one task per scenario.
module tb_pi_ebus_seq;

    logic        clk_pi_h = 1'b0;
    logic        mr_reset_l = 1'b0;
    logic [6:0]  ebus_pi_h = '0;
    logic        pi_on_h = 1'b0;
    logic [6:0]  pi_level_on_h = '0;
    logic [6:0]  pi_hold_h = '0;
    logic        ebus_grant_h = 1'b0;
    logic        ebus_xfer_h = 1'b0;
    logic [35:0] ebus_d_h = '0;
    logic        ebus_req_h, ebus_demand_h, pi_vec_valid_h, pi_timeout_h, pi_busy_h;
    logic [2:0]  ebus_f_h, ebus_cs_h, pi_vec_level_h;
    logic [35:0] pi_vec_h;

    int n_vec = 0;
    int n_err = 0;

    pi_ebus_seq #(.DATA_W(36), .TMO_CYC(8), .FCN_CODE(3'b001)) dut (
        .clk_pi_h(clk_pi_h), .mr_reset_l(mr_reset_l), .ebus_pi_h(ebus_pi_h),
        .pi_on_h(pi_on_h), .pi_level_on_h(pi_level_on_h), .pi_hold_h(pi_hold_h),
        .ebus_grant_h(ebus_grant_h), .ebus_xfer_h(ebus_xfer_h), .ebus_d_h(ebus_d_h),
        .ebus_req_h(ebus_req_h), .ebus_demand_h(ebus_demand_h), .ebus_f_h(ebus_f_h),
        .ebus_cs_h(ebus_cs_h), .pi_vec_valid_h(pi_vec_valid_h), .pi_vec_h(pi_vec_h),
        .pi_vec_level_h(pi_vec_level_h), .pi_timeout_h(pi_timeout_h), .pi_busy_h(pi_busy_h)
    );

    always #5 clk_pi_h = ~clk_pi_h;

    task automatic tick;
        @(posedge clk_pi_h);
        #1;
    endtask

    task automatic test_reset;
        ebus_pi_h = 7'b0000001; pi_on_h = 1'b1; pi_level_on_h = 7'h7f;
        tick; tick;
        n_vec++; if (ebus_req_h !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0h exp=0", ebus_req_h); end
        n_vec++; if (pi_busy_h !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", pi_busy_h); end
        n_vec++; if ({ebus_demand_h, ebus_f_h, ebus_cs_h, pi_vec_valid_h, pi_timeout_h, pi_vec_level_h} !== 12'd0)
            begin n_err++; $display("FAIL reset_outs got=%0h exp=0", {ebus_demand_h, ebus_f_h, ebus_cs_h, pi_vec_valid_h, pi_timeout_h, pi_vec_level_h}); end
        n_vec++; if (pi_vec_h !== 36'd0) begin n_err++; $display("FAIL reset_vec got=%0o exp=0", pi_vec_h); end
        ebus_pi_h = '0;
        mr_reset_l = 1'b1;
        tick;
        $display("test_reset done");
    endtask

    task automatic test_basic;
        ebus_pi_h = 7'b0010100;
        tick;
        n_vec++; if (ebus_req_h !== 1'b1) begin n_err++; $display("FAIL basic_req got=%0h exp=1", ebus_req_h); end
        n_vec++; if (ebus_demand_h !== 1'b0) begin n_err++; $display("FAIL basic_nodemand got=%0h exp=0", ebus_demand_h); end
        tick;
        n_vec++; if (ebus_demand_h !== 1'b0) begin n_err++; $display("FAIL basic_wait_grant got=%0h exp=0", ebus_demand_h); end
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if (ebus_demand_h !== 1'b1) begin n_err++; $display("FAIL basic_demand got=%0h exp=1", ebus_demand_h); end
        n_vec++; if (ebus_cs_h !== 3'd3) begin n_err++; $display("FAIL basic_cs got=%0d exp=3", ebus_cs_h); end
        n_vec++; if (ebus_f_h !== 3'd1) begin n_err++; $display("FAIL basic_f got=%0d exp=1", ebus_f_h); end
        ebus_grant_h = 1'b0;
        tick; tick;
        n_vec++; if ({ebus_req_h, ebus_demand_h, ebus_cs_h} !== {2'b11, 3'd3}) begin n_err++; $display("FAIL basic_grant_drop got=%0h exp=1b", {ebus_req_h, ebus_demand_h, ebus_cs_h}); end
        ebus_xfer_h = 1'b1; ebus_d_h = 36'o123456701234; ebus_pi_h = '0;
        tick;
        n_vec++; if (ebus_demand_h !== 1'b0) begin n_err++; $display("FAIL basic_demand_drop got=%0h exp=0", ebus_demand_h); end
        n_vec++; if (pi_vec_h !== 36'o123456701234) begin n_err++; $display("FAIL basic_vec got=%0o exp=123456701234", pi_vec_h); end
        n_vec++; if (pi_vec_level_h !== 3'd3) begin n_err++; $display("FAIL basic_vec_level got=%0d exp=3", pi_vec_level_h); end
        n_vec++; if (pi_vec_valid_h !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%0h exp=0", pi_vec_valid_h); end
        ebus_xfer_h = 1'b0;
        tick;
        n_vec++; if (pi_vec_valid_h !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%0h exp=1", pi_vec_valid_h); end
        n_vec++; if ({ebus_req_h, ebus_f_h, ebus_cs_h} !== 7'd0) begin n_err++; $display("FAIL basic_release got=%0h exp=0", {ebus_req_h, ebus_f_h, ebus_cs_h}); end
        tick;
        n_vec++; if ({pi_vec_valid_h, pi_busy_h} !== 2'b00) begin n_err++; $display("FAIL basic_idle got=%0h exp=0", {pi_vec_valid_h, pi_busy_h}); end
        $display("test_basic done");
    endtask

    task automatic test_hold;
        ebus_pi_h = 7'b0000010; pi_hold_h = 7'b0000001;
        tick; tick;
        n_vec++; if ({ebus_req_h, pi_busy_h} !== 2'b00) begin n_err++; $display("FAIL hold_blocked got=%0h exp=0", {ebus_req_h, pi_busy_h}); end
        pi_hold_h = '0;
        tick;
        n_vec++; if (ebus_req_h !== 1'b1) begin n_err++; $display("FAIL hold_release_req got=%0h exp=1", ebus_req_h); end
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if (ebus_cs_h !== 3'd2) begin n_err++; $display("FAIL hold_cs got=%0d exp=2", ebus_cs_h); end
        ebus_grant_h = 1'b0; ebus_pi_h = '0; ebus_xfer_h = 1'b1; ebus_d_h = 36'o7;
        tick;
        ebus_xfer_h = 1'b0;
        tick;
        n_vec++; if ({pi_vec_valid_h, pi_vec_level_h} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL hold_valid got=%0h exp=a", {pi_vec_valid_h, pi_vec_level_h}); end
        tick;
        $display("test_hold done");
    endtask

    task automatic test_timeout;
        ebus_pi_h = 7'b0000001;
        tick;
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if (ebus_demand_h !== 1'b1) begin n_err++; $display("FAIL tmo_demand got=%0h exp=1", ebus_demand_h); end
        ebus_grant_h = 1'b0; ebus_pi_h = '0;
        for (int i = 1; i <= 7; i++) begin
            tick;
            n_vec++; if ({ebus_demand_h, pi_timeout_h} !== 2'b10) begin n_err++; $display("FAIL tmo_early_c%0d got=%0h exp=2", i, {ebus_demand_h, pi_timeout_h}); end
        end
        tick;
        n_vec++; if (pi_timeout_h !== 1'b1) begin n_err++; $display("FAIL tmo_pulse got=%0h exp=1", pi_timeout_h); end
        n_vec++; if ({ebus_demand_h, ebus_req_h, pi_vec_valid_h} !== 3'b000) begin n_err++; $display("FAIL tmo_drop got=%0h exp=0", {ebus_demand_h, ebus_req_h, pi_vec_valid_h}); end
        n_vec++; if (pi_vec_h !== 36'o7) begin n_err++; $display("FAIL tmo_vec_kept got=%0o exp=7", pi_vec_h); end
        tick;
        n_vec++; if ({pi_timeout_h, pi_vec_valid_h, pi_busy_h} !== 3'b000) begin n_err++; $display("FAIL tmo_idle got=%0h exp=0", {pi_timeout_h, pi_vec_valid_h, pi_busy_h}); end
        $display("test_timeout done");
    endtask

    task automatic test_no_preempt;
        ebus_pi_h = 7'b0010000;
        tick;
        ebus_pi_h = 7'b0010001;
        tick;
        n_vec++; if ({ebus_req_h, ebus_demand_h} !== 2'b10) begin n_err++; $display("FAIL npre_req got=%0h exp=2", {ebus_req_h, ebus_demand_h}); end
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if (ebus_cs_h !== 3'd5) begin n_err++; $display("FAIL npre_cs5 got=%0d exp=5", ebus_cs_h); end
        ebus_grant_h = 1'b0; ebus_pi_h = 7'b0000001; ebus_xfer_h = 1'b1; ebus_d_h = 36'o555;
        tick;
        n_vec++; if (pi_vec_level_h !== 3'd5) begin n_err++; $display("FAIL npre_lvl5 got=%0d exp=5", pi_vec_level_h); end
        ebus_xfer_h = 1'b0;
        tick; tick; tick;
        n_vec++; if (ebus_req_h !== 1'b1) begin n_err++; $display("FAIL npre_next_req got=%0h exp=1", ebus_req_h); end
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if (ebus_cs_h !== 3'd1) begin n_err++; $display("FAIL npre_cs1 got=%0d exp=1", ebus_cs_h); end
        ebus_grant_h = 1'b0; ebus_pi_h = '0; ebus_xfer_h = 1'b1; ebus_d_h = 36'o111;
        tick;
        ebus_xfer_h = 1'b0;
        tick;
        n_vec++; if ({pi_vec_valid_h, pi_vec_level_h} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL npre_lvl1 got=%0h exp=9", {pi_vec_valid_h, pi_vec_level_h}); end
        tick;
        $display("test_no_preempt done");
    endtask

    task automatic test_abandon;
        ebus_pi_h = 7'b0000001;
        tick;
        pi_on_h = 1'b0;
        tick;
        n_vec++; if ({ebus_req_h, pi_busy_h} !== 2'b00) begin n_err++; $display("FAIL abandon got=%0h exp=0", {ebus_req_h, pi_busy_h}); end
        tick;
        n_vec++; if (ebus_req_h !== 1'b0) begin n_err++; $display("FAIL abandon_off got=%0h exp=0", ebus_req_h); end
        pi_on_h = 1'b1; ebus_pi_h = '0;
        $display("test_abandon done");
    endtask

    task automatic test_xfer_at_tmo;
        ebus_pi_h = 7'b0000001;
        tick;
        ebus_grant_h = 1'b1;
        tick;
        ebus_grant_h = 1'b0; ebus_pi_h = '0;
        repeat (7) tick;
        n_vec++; if ({ebus_demand_h, pi_timeout_h} !== 2'b10) begin n_err++; $display("FAIL xtmo_pre got=%0h exp=2", {ebus_demand_h, pi_timeout_h}); end
        ebus_xfer_h = 1'b1; ebus_d_h = 36'o4321;
        tick;
        n_vec++; if ({pi_timeout_h, ebus_demand_h} !== 2'b00) begin n_err++; $display("FAIL xtmo_no_tmo got=%0h exp=0", {pi_timeout_h, ebus_demand_h}); end
        n_vec++; if (pi_vec_h !== 36'o4321) begin n_err++; $display("FAIL xtmo_vec got=%0o exp=4321", pi_vec_h); end
        ebus_xfer_h = 1'b0;
        tick;
        n_vec++; if ({pi_vec_valid_h, pi_timeout_h} !== 2'b10) begin n_err++; $display("FAIL xtmo_valid got=%0h exp=2", {pi_vec_valid_h, pi_timeout_h}); end
        tick;
        $display("test_xfer_at_tmo done");
    endtask

    task automatic test_reset_mid;
        ebus_pi_h = 7'b1000000;
        tick;
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if ({ebus_demand_h, ebus_cs_h} !== {1'b1, 3'd7}) begin n_err++; $display("FAIL rmid_demand got=%0h exp=f", {ebus_demand_h, ebus_cs_h}); end
        ebus_grant_h = 1'b0; mr_reset_l = 1'b0;
        tick;
        n_vec++; if ({ebus_req_h, ebus_demand_h, ebus_f_h, ebus_cs_h, pi_vec_valid_h, pi_timeout_h, pi_busy_h, pi_vec_level_h} !== 15'd0)
            begin n_err++; $display("FAIL rmid_outs got=%0h exp=0", {ebus_req_h, ebus_demand_h, ebus_f_h, ebus_cs_h, pi_vec_valid_h, pi_timeout_h, pi_busy_h, pi_vec_level_h}); end
        n_vec++; if (pi_vec_h !== 36'd0) begin n_err++; $display("FAIL rmid_vec got=%0o exp=0", pi_vec_h); end
        mr_reset_l = 1'b1;
        tick;
        n_vec++; if (ebus_req_h !== 1'b1) begin n_err++; $display("FAIL rmid_restart got=%0h exp=1", ebus_req_h); end
        ebus_grant_h = 1'b1;
        tick;
        n_vec++; if ({ebus_demand_h, ebus_cs_h} !== {1'b1, 3'd7}) begin n_err++; $display("FAIL rmid_demand2 got=%0h exp=f", {ebus_demand_h, ebus_cs_h}); end
        ebus_grant_h = 1'b0; ebus_pi_h = '0; ebus_xfer_h = 1'b1; ebus_d_h = 36'o707;
        tick;
        ebus_xfer_h = 1'b0;
        tick;
        n_vec++; if ({pi_vec_valid_h, pi_vec_h} !== {1'b1, 36'o707}) begin n_err++; $display("FAIL rmid_valid got=%0o exp=1000000000707", {pi_vec_valid_h, pi_vec_h}); end
        tick;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_timeout;
        test_no_preempt;
        test_abandon;
        test_xfer_at_tmo;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
